// File: rtl/life_pkg.sv
// Shared constants, report FSM states and frame sizing helper for the life result reporter.
package life_pkg;

    localparam logic [7:0] LIFE_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        STEP,
        RNG,
        CSUM
    } report_state_e;

    // Number of rng bytes needed to carry an INIT x INIT soup.
    function automatic int unsigned life_nb(input int unsigned init);
        return (init * init + 7) / 8;
    endfunction

endpackage

// File: rtl/life_report_buf.sv
// One-entry pending result buffer: payload register plus full flag.
// A load together with a pop replaces the payload and leaves the buffer full.
module life_report_buf #(
    parameter int unsigned W = 432
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic [W-1:0] r_data;
    logic         r_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/life_report.sv
// Serialises life core results as checksummed byte frames on a valid/ready stream.
// Define LIFE_REPORT_BEST_EN to forward only results whose best_step beats the best seen so far.
module life_report
    import life_pkg::*;
#(
    parameter int unsigned INIT = 20,
    parameter int unsigned NB   = life_nb(INIT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  life,
    input  logic [INIT*INIT+31:0] life_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned RW = INIT * INIT;
    localparam int unsigned W  = RW + 32;
    localparam int unsigned PW = NB * 8;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

    report_state_e r_state, w_state_nxt;
    logic [1:0]    r_step_cnt, w_step_nxt;
    logic [CW-1:0] r_rng_cnt, w_rng_nxt;
    logic [7:0]    r_csum, r_tx_data, w_byte_nxt;
    logic          r_tx_valid, r_busy, r_overrun;
    logic [W-1:0]  r_active, w_pend_q;
    logic [31:0]   w_step_word;
    logic [PW-1:0] w_rng_pad;
    logic          w_pend_full, w_fire, w_csum_done, w_accept, w_drop;
    logic          w_pend_load, w_pend_pop, w_act_load_life, w_act_load_pend;

    assign w_fire      = r_tx_valid & tx_ready;
    assign w_csum_done = (r_state == CSUM) && w_fire;
    assign w_step_word = r_active[W-1 -: 32];
    assign w_rng_pad   = PW'(r_active[RW-1:0]);

`ifdef LIFE_REPORT_BEST_EN
    logic [31:0] r_record;

    assign w_accept = life && (life_data[W-1 -: 32] > r_record);

    // Record tracks only results that were actually kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_record <= '0;
        end else if (w_accept && !w_drop) begin
            r_record <= life_data[W-1 -: 32];
        end
    end
`else
    assign w_accept = life;
`endif

    // Capture routing. A result landing on the checksum handshake with nothing
    // pending goes straight to the active register so the next frame has no gap.
    always_comb begin
        w_act_load_life = 1'b0;
        w_act_load_pend = 1'b0;
        w_pend_load     = 1'b0;
        w_pend_pop      = 1'b0;
        w_drop          = 1'b0;
        if (r_state == IDLE) begin
            w_act_load_life = w_accept;
        end else if (w_csum_done) begin
            if (w_pend_full) begin
                w_pend_pop      = 1'b1;
                w_act_load_pend = 1'b1;
                w_pend_load     = w_accept;
            end else begin
                w_act_load_life = w_accept;
            end
        end else if (w_accept) begin
            if (w_pend_full) begin
                w_drop = 1'b1;
            end else begin
                w_pend_load = 1'b1;
            end
        end
    end

    life_report_buf #(
        .W (W)
    ) u_pend (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_pend_load),
        .i_pop  (w_pend_pop),
        .i_data (life_data),
        .o_data (w_pend_q),
        .o_full (w_pend_full)
    );

    // Next state, counters and the byte to present after this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step_cnt;
        w_rng_nxt   = r_rng_cnt;
        w_byte_nxt  = r_tx_data;
        case (r_state)
            IDLE: if (w_act_load_life) w_state_nxt = SYNC;
            SYNC: if (w_fire) begin
                w_state_nxt = STEP;
                w_step_nxt  = 2'd0;
            end
            STEP: if (w_fire) begin
                if (r_step_cnt == 2'd3) begin
                    w_state_nxt = RNG;
                    w_rng_nxt   = '0;
                end else begin
                    w_step_nxt = r_step_cnt + 2'd1;
                end
            end
            RNG: if (w_fire) begin
                if (r_rng_cnt == CW'(NB - 1)) begin
                    w_state_nxt = CSUM;
                end else begin
                    w_rng_nxt = r_rng_cnt + CW'(1);
                end
            end
            CSUM: if (w_fire) begin
                w_state_nxt = (w_act_load_life || w_act_load_pend) ? SYNC : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_fire || (r_state == IDLE)) begin
            case (w_state_nxt)
                SYNC:    w_byte_nxt = LIFE_SYNC;
                STEP:    w_byte_nxt = 8'(w_step_word >> {~w_step_nxt, 3'b000});
                RNG:     w_byte_nxt = 8'(w_rng_pad >> {w_rng_nxt, 3'b000});
                CSUM:    w_byte_nxt = r_csum ^ r_tx_data;
                default: w_byte_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_step_cnt <= '0;
            r_rng_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_cnt <= w_step_nxt;
            r_rng_cnt  <= w_rng_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_active   <= '0;
            r_csum     <= 8'h00;
        end else begin
            r_tx_data  <= w_byte_nxt;
            r_tx_valid <= (w_state_nxt != IDLE);
            r_busy     <= (w_state_nxt != IDLE);
            if (w_drop) r_overrun <= 1'b1;
            if (w_act_load_life) begin
                r_active <= life_data;
            end else if (w_act_load_pend) begin
                r_active <= w_pend_q;
            end
            if ((w_state_nxt == SYNC) && (r_state != SYNC)) begin
                r_csum <= 8'h00;
            end else if (w_fire && ((r_state == STEP) || (r_state == RNG))) begin
                r_csum <= r_csum ^ r_tx_data;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule
